// File: rtl/counter_pkg.sv
// Shared types for the up/down counter slice: direction and terminal-value behaviour.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: step in the requested direction, flagging
// wrap or saturation events at the 0 / MAX boundaries.
module counter_next
    import counter_pkg::*;
#(
    parameter int              N        = 4,
    parameter longint unsigned MAX      = (64'd1 << N) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic [N-1:0] count,
    input  logic         up,
    output logic [N-1:0] nxt,
    output logic         at_term,
    output logic         wrap_ev,
    output logic         sat_ev
);

    localparam logic [N-1:0] MAXV = N'(MAX);
    localparam mode_t        MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    dir_t dir;
    logic at_max, at_zero;

    assign dir     = dir_t'(up);
    assign at_max  = (count == MAXV);
    assign at_zero = (count == '0);
    assign at_term = (dir == DIR_UP) ? at_max : at_zero;

    always_comb begin
        nxt     = count;
        wrap_ev = 1'b0;
        sat_ev  = 1'b0;
        if (at_term) begin
            // Boundary: either roll to the opposite end or stick in place
            if (MODE == MODE_SAT) begin
                sat_ev = 1'b1;
            end else begin
                wrap_ev = 1'b1;
                nxt     = (dir == DIR_UP) ? '0 : MAXV;
            end
        end else if (dir == DIR_UP) begin
            nxt = count + N'(1);
        end else begin
            nxt = count - N'(1);
        end
    end

endmodule

// File: rtl/counter_updown_n.sv
// Modulo-(MAX+1) up/down counter with load, clear, wrap pulse and sticky
// saturation flag. Priority per edge: reset > clear > load > en.
module counter_updown_n
    import counter_pkg::*;
#(
    parameter int              N        = 4,
    parameter longint unsigned MAX      = (64'd1 << N) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrapped,
    output logic         sat
);

    localparam logic [N-1:0] MAXV = N'(MAX);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("counter_updown_n: N=%0d out of range 2..32", N);
    end
    if (MAX < 1 || MAX > ((64'd1 << N) - 64'd1)) begin : g_bad_max
        $error("counter_updown_n: MAX=%0d out of range 1..2**N-1", MAX);
    end

    logic [N-1:0] nxt;
    logic         at_term, wrap_ev, sat_ev;

    counter_next #(
        .N        (N),
        .MAX      (MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .count   (count),
        .up      (up),
        .nxt     (nxt),
        .at_term (at_term),
        .wrap_ev (wrap_ev),
        .sat_ev  (sat_ev)
    );

    assign tc = en & ~load & ~clear & ~reset & at_term;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count   <= '0;
            wrapped <= 1'b0;
            sat     <= 1'b0;
        end else if (load) begin
            // Out-of-range loads clamp so count never exceeds MAX
            count   <= (load_val > MAXV) ? MAXV : load_val;
            wrapped <= 1'b0;
        end else if (en) begin
            count   <= nxt;
            wrapped <= wrap_ev;
            if (sat_ev) sat <= 1'b1;
        end else begin
            wrapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_updown_n.sv
// Three counter variants (wrap MAX=9, saturate MAX=9, wrap MAX=1) driven by
// shared stimulus and compared every cycle against an arithmetic model.
module tb_counter_updown_n;

    localparam int N = 4;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset, clear, load, en, up;
    logic [N-1:0] load_val;
    logic [N-1:0] count [NDUT];
    logic tc [NDUT], wrapped [NDUT], sat [NDUT];

    int mx [NDUT] = '{9, 9, 1};
    bit sm [NDUT] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [NDUT];
    bit m_wr [NDUT], m_sat [NDUT];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    counter_updown_n #(.N(N), .MAX(9), .SATURATE(0)) u_wrap9 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count[0]), .tc(tc[0]), .wrapped(wrapped[0]), .sat(sat[0]));
    counter_updown_n #(.N(N), .MAX(9), .SATURATE(1)) u_sat9 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count[1]), .tc(tc[1]), .wrapped(wrapped[1]), .sat(sat[1]));
    counter_updown_n #(.N(N), .MAX(1), .SATURATE(0)) u_wrap1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count[2]), .tc(tc[2]), .wrapped(wrapped[2]), .sat(sat[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
        reset = r; clear = c; load = l; load_val = N'(lv); en = e; up = u;
    endtask

    // Reference: count lives on the ring 0..MAX; a step leaving the ring either
    // wraps modulo MAX+1 or is refused (saturate).
    task automatic model_step(input int i);
        int step;
        if (reset || clear) begin
            m_cnt[i] = 0; m_wr[i] = 0; m_sat[i] = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) < mx[i]) ? int'(load_val) : mx[i];
            m_wr[i] = 0;
        end else if (en) begin
            step = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            m_wr[i] = 0;
            if (step < 0 || step > mx[i]) begin
                if (sm[i]) m_sat[i] = 1;
                else begin
                    m_cnt[i] = (step + mx[i] + 1) % (mx[i] + 1);
                    m_wr[i] = 1;
                end
            end else m_cnt[i] = step;
        end else m_wr[i] = 0;
    endtask

    task automatic cyc(input bit do_chk = 1'b1);
        bit etc;
        #1;
        if (do_chk) for (int i = 0; i < NDUT; i++) begin
            etc = en && !load && !clear && !reset &&
                  ((up && m_cnt[i] == mx[i]) || (!up && m_cnt[i] == 0));
            chk($sformatf("tc%0d", i), 64'(tc[i]), 64'(etc));
        end
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_step(i);
        @(negedge clk);
        if (do_chk) for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("count%0d", i), 64'(count[i]), 64'(m_cnt[i]));
            chk($sformatf("wrapped%0d", i), 64'(wrapped[i]), 64'(m_wr[i]));
            chk($sformatf("sat%0d", i), 64'(sat[i]), 64'(m_sat[i]));
            chk($sformatf("le_max%0d", i), 64'(int'(count[i]) <= mx[i]), 64'd1);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc(1'b0);
        chk("rst_count", 64'(count[0]), 64'd0);
        chk("rst_wrapped", 64'(wrapped[0]), 64'd0);
        chk("rst_sat", 64'(sat[1]), 64'd0);
        // tc held low while reset is high even at a terminal condition
        drive(1, 0, 0, 0, 1, 0);
        cyc();

        // Count up through the 9->0 wrap
        drive(0, 0, 0, 0, 1, 1);
        repeat (9) cyc();
        chk("up_at9", 64'(count[0]), 64'd9);
        chk("tc_at9", 64'(tc[0]), 64'd1);
        cyc();
        chk("wrap_to0", 64'(count[0]), 64'd0);
        chk("wrap_pulse", 64'(wrapped[0]), 64'd1);
        repeat (2) cyc();
        chk("up_end", 64'(count[0]), 64'd2);

        // Out-of-range load clamps to MAX, then count down
        drive(0, 0, 1, 15, 0, 0);
        cyc();
        chk("load_clamp", 64'(count[0]), 64'd9);
        chk("load_clamp1", 64'(count[2]), 64'd1);
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) cyc();
        chk("down3", 64'(count[0]), 64'd6);

        // Saturating variant pinned at 0 going down
        drive(0, 1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) cyc();
        chk("sat_hold", 64'(count[1]), 64'd0);
        chk("sat_sticky", 64'(sat[1]), 64'd1);
        chk("sat_nowrap", 64'(wrapped[1]), 64'd0);
        drive(0, 1, 0, 0, 0, 0);
        cyc();
        chk("sat_clear", 64'(sat[1]), 64'd0);

        // Reset beats everything; load beats en
        drive(0, 0, 1, 5, 0, 0);
        cyc();
        drive(1, 1, 1, 7, 1, 1);
        cyc();
        chk("rst_prio", 64'(count[0]), 64'd0);
        drive(0, 0, 1, 3, 1, 1);
        cyc();
        chk("load_prio", 64'(count[0]), 64'd3);

        // MAX=1 toggling: back-to-back wrap pulses
        drive(0, 1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 1, 1);
        repeat (6) cyc();
        chk("max1_end", 64'(count[2]), 64'd0);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0), int'($urandom_range(15)),
                  ($urandom_range(3) != 0), $urandom_range(1) == 1);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_updown_n.md
COUNTER_UPDOWN_N -- requirements
Module: counter_updown_N

Interface
REQ-001 Parameter N, default 4: counter width in bits; SHALL be 2..32.
REQ-002 Parameter MAX, default 2**N-1: terminal (modulus-1) value; SHALL satisfy 1 <= MAX <= 2**N-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at terminal value, 1 = hold at terminal value.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous zeroing of count, lower priority than reset.
REQ-007 load  input  1  load load_val into count.
REQ-008 load_val  input  N  value to load.
REQ-009 en  input  1  count enable.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  N  registered counter value.
REQ-012 tc  output  1  combinational terminal-count strobe.
REQ-013 wrapped  output  1  registered one-cycle pulse after a wrap event.
REQ-014 sat  output  1  registered sticky flag: saturation was hit since last reset/clear.

Function
REQ-015 Per-edge priority SHALL be reset > clear > load > en; lower-priority inputs ignored that cycle.
REQ-016 clear SHALL set count=0, wrapped=0, sat=0.
REQ-017 load SHALL set count=min(load_val, MAX); wrapped=0; sat unchanged.
REQ-018 en=1, up=1, count<MAX: count SHALL become count+1.
REQ-019 en=1, up=0, count>0: count SHALL become count-1.
REQ-020 en=1, up=1, count==MAX: SATURATE=0 -> count=0 and wrapped=1 next cycle; SATURATE=1 -> count held, sat=1.
REQ-021 en=1, up=0, count==0: SATURATE=0 -> count=MAX and wrapped=1 next cycle; SATURATE=1 -> count held, sat=1.
REQ-022 en=0 and no clear/load: count SHALL hold; wrapped SHALL be 0.
REQ-023 wrapped SHALL be high exactly one cycle per wrap event; consecutive wraps (e.g. MAX=1 toggling) give consecutive pulses.
REQ-024 tc SHALL equal en & ~load & ~clear & ~reset & ((up & count==MAX) | (~up & count==0)), zero latency.
REQ-025 Direction change takes effect on the same edge that samples up; no pipeline latency on count.
REQ-026 count SHALL never exceed MAX in any cycle, including after load of out-of-range value.
REQ-027 Arithmetic SHALL be N bits wide with no intermediate overflow; comparisons use MAX cast to N bits.

Reset
REQ-028 On reset=1 at a rising edge: count=0, wrapped=0, sat=0; tc=0 while reset is high.
REQ-029 Reset mid-count SHALL discard any simultaneous clear/load/en; counting resumes from 0 on the first edge with reset=0.
REQ-030 No asynchronous reset path; output values before the first reset edge are undefined.

Structure
REQ-031 Shared package counter_pkg SHALL hold typedef dir_t (DIR_DOWN=0, DIR_UP=1) and typedef mode_t (MODE_WRAP=0, MODE_SAT=1).
REQ-032 Sub-module counter_next (combinational) SHALL compute next value, wrap-event and sat-event from count, up, MAX, SATURATE; top holds registers and priority.
REQ-033 Elaboration SHALL fail on illegal N/MAX via static assertion.

Verification (N=4, MAX=9 unless noted)
REQ-034 reset 1 cycle, en=1, up=1 for 12 cycles -> count 1..9,0,1,2; wrapped high only cycle after 9->0; tc high while count==9.
REQ-035 load_val=15, load=1 -> count=9 next cycle; then up=0, en=1 -> 8,7,...
REQ-036 SATURATE=1, count=0, up=0, en=1 3 cycles -> count stays 0, sat=1 sticky, wrapped stays 0; clear -> sat=0.
REQ-037 count=5, reset=1 with load=1, clear=1, en=1 same cycle -> count=0; load=1 with en=1 -> loaded value wins.
REQ-038 MAX=1, en=1, up=1 6 cycles -> count 1,0,1,0,1,0; wrapped pulses on every second cycle.
REQ-039 Random en/up/load/clear for 10k cycles vs reference model -> count<=MAX always, exact match every cycle.
